occupancy_monitor: RTL and testbench

//  Parametrised lot-occupancy monitor: NUM_GATES independent two-sensor gates (a outer, b inner).

---
 rtl/occupancy_monitor_if.sv | 30 +++
 rtl/occupancy_monitor.sv | 185 ++++++++++++++++++
 tb/tb_occupancy_monitor.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/occupancy_monitor_if.sv
// Sensor inputs and status outputs of the lot-occupancy monitor.
// The monitor connects through the slave modport and the driving side through the master modport.
interface occupancy_monitor_if #(
  parameter int unsigned NUM_GATES = 2,
  parameter int unsigned CAPACITY  = 25
);
  localparam int unsigned CNT_W = $clog2(CAPACITY + 1);

  logic [NUM_GATES-1:0] a;
  logic [NUM_GATES-1:0] b;
  logic [NUM_GATES-1:0] enter_evt;
  logic [NUM_GATES-1:0] exit_evt;
  logic                 reject;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic [6:0]           HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  modport master (
    output a, b,
    input  enter_evt, exit_evt, reject, count, full, empty,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  a, b,
    output enter_evt, exit_evt, reject, count, full, empty,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/occupancy_monitor.sv
// Lot-occupancy monitor: per-gate sensor synchronisers and direction FSMs feeding one
// saturating occupancy counter with full/empty flags and a six-digit status display.
module occupancy_monitor #(
  parameter int unsigned CAPACITY    = 25,
  parameter int unsigned NUM_GATES   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                reset,
  occupancy_monitor_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(CAPACITY + 1);
  localparam int unsigned SUM_W = CNT_W + 3;

  typedef enum logic [2:0] {
    StIdle, StIn1, StIn2, StIn3, StOut1, StOut2, StOut3, StErr
  } state_e;

  logic [SYNC_STAGES-1:0] sync_a_q [NUM_GATES];
  logic [SYNC_STAGES-1:0] sync_b_q [NUM_GATES];
  logic [1:0]             ab       [NUM_GATES];
  state_e                 state_q  [NUM_GATES];
  state_e                 state_d  [NUM_GATES];
  logic [NUM_GATES-1:0]   enter_d, enter_q, exit_d, exit_q;
  logic [CNT_W-1:0]       count_d, count_q;
  logic                   reject_d, reject_q;
  logic [SUM_W-1:0]       sum;
  logic                   sum_neg, sum_over;
  logic [7:0]             cnt8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GATES; i++) begin
        sync_a_q[i] <= '0;
        sync_b_q[i] <= '0;
        state_q[i]  <= StIdle;
      end
      enter_q  <= '0;
      exit_q   <= '0;
      count_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GATES; i++) begin
        sync_a_q[i] <= {sync_a_q[i][SYNC_STAGES-2:0], bus.a[i]};
        sync_b_q[i] <= {sync_b_q[i][SYNC_STAGES-2:0], bus.b[i]};
        state_q[i]  <= state_d[i];
      end
      enter_q  <= enter_d;
      exit_q   <= exit_d;
      count_q  <= count_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_GATES; i++) begin
      ab[i] = {sync_a_q[i][SYNC_STAGES-1], sync_b_q[i][SYNC_STAGES-1]};
    end
  end

  // Exit states mirror entry states with a and b swapped.
  always_comb begin
    enter_d = '0;
    exit_d  = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        StIdle: case (ab[i])
          2'b10:   state_d[i] = StIn1;
          2'b01:   state_d[i] = StOut1;
          2'b11:   state_d[i] = StErr;
          default: ;
        endcase
        StIn1: case (ab[i])
          2'b11:   state_d[i] = StIn2;
          2'b00:   state_d[i] = StIdle;
          2'b01:   state_d[i] = StErr;
          default: ;
        endcase
        StIn2: case (ab[i])
          2'b01:   state_d[i] = StIn3;
          2'b10:   state_d[i] = StIn1;
          2'b00:   state_d[i] = StErr;
          default: ;
        endcase
        StIn3: case (ab[i])
          2'b00: begin
            state_d[i] = StIdle;
            enter_d[i] = 1'b1;
          end
          2'b11:   state_d[i] = StIn2;
          2'b10:   state_d[i] = StErr;
          default: ;
        endcase
        StOut1: case (ab[i])
          2'b11:   state_d[i] = StOut2;
          2'b00:   state_d[i] = StIdle;
          2'b10:   state_d[i] = StErr;
          default: ;
        endcase
        StOut2: case (ab[i])
          2'b10:   state_d[i] = StOut3;
          2'b01:   state_d[i] = StOut1;
          2'b00:   state_d[i] = StErr;
          default: ;
        endcase
        StOut3: case (ab[i])
          2'b00: begin
            state_d[i] = StIdle;
            exit_d[i]  = 1'b1;
          end
          2'b11:   state_d[i] = StOut2;
          2'b01:   state_d[i] = StErr;
          default: ;
        endcase
        StErr: if (ab[i] == 2'b00) state_d[i] = StIdle;
      endcase
    end
  end

  // Two's-complement sum with headroom so underflow shows up as a set sign bit.
  always_comb begin
    sum = SUM_W'(count_q);
    for (int i = 0; i < NUM_GATES; i++) begin
      if (enter_q[i]) sum = sum + SUM_W'(1);
      if (exit_q[i])  sum = sum - SUM_W'(1);
    end
    sum_neg  = sum[SUM_W-1];
    sum_over = !sum_neg && (sum > SUM_W'(CAPACITY));
    reject_d = sum_neg || sum_over;
    if (sum_neg)       count_d = '0;
    else if (sum_over) count_d = CNT_W'(CAPACITY);
    else               count_d = sum[CNT_W-1:0];
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  assign cnt8          = 8'(count_q);
  assign bus.enter_evt = enter_q;
  assign bus.exit_evt  = exit_q;
  assign bus.reject    = reject_q;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CNT_W'(CAPACITY));
  assign bus.empty     = (count_q == '0);

  always_comb begin
    bus.HEX5 = 7'h7F;
    bus.HEX4 = 7'h7F;
    bus.HEX3 = 7'h7F;
    bus.HEX2 = 7'h7F;
    bus.HEX1 = 7'h7F;
    bus.HEX0 = seg(4'(cnt8 % 8'd10));
    if (count_q == '0) begin
      bus.HEX5 = 7'h46;
      bus.HEX4 = 7'h47;
      bus.HEX3 = 7'h06;
      bus.HEX2 = 7'h08;
      bus.HEX1 = 7'h2F;
      bus.HEX0 = 7'h40;
    end else if (count_q == CNT_W'(CAPACITY)) begin
      bus.HEX5 = 7'h0E;
      bus.HEX4 = 7'h41;
      bus.HEX3 = 7'h47;
      bus.HEX2 = 7'h47;
      bus.HEX1 = seg(4'(CAPACITY / 10));
      bus.HEX0 = seg(4'(CAPACITY % 10));
    end else if (cnt8 >= 8'd10) begin
      bus.HEX1 = seg(4'(cnt8 / 8'd10));
    end
  end
endmodule

// File: tb/tb_occupancy_monitor.sv
// Scoreboard bench for occupancy_monitor: stimulus pushes expected events and count updates,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_occupancy_monitor;
  localparam int Cap = 25;

  typedef struct packed { logic [1:0] ent; logic [1:0] ext; } evt_t;
  typedef struct packed { logic [4:0] cnt; logic rej; } upd_t;

  localparam logic [9:0] SeqIdle = 10'b00_00_00_00_00;
  localparam logic [9:0] SeqEnt  = 10'b00_10_11_01_00;
  localparam logic [9:0] SeqExt  = 10'b00_01_11_10_00;
  localparam logic [9:0] SeqBack = 10'b00_10_11_10_00;
  localparam logic [9:0] SeqErr  = 10'b00_11_01_00_00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  occupancy_monitor_if #(.NUM_GATES(2), .CAPACITY(Cap)) bus ();

  occupancy_monitor #(.CAPACITY(Cap), .NUM_GATES(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  evt_t evt_sb[$];
  upd_t upd_sb[$];
  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  logic [4:0] prev_cnt = '0;
  evt_t e;
  upd_t u;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic chk_hex(input string name, input logic [6:0] h5, h4, h3, h2, h1, h0);
    chk({name, "_hex5"}, bus.HEX5, h5);
    chk({name, "_hex4"}, bus.HEX4, h4);
    chk({name, "_hex3"}, bus.HEX3, h3);
    chk({name, "_hex2"}, bus.HEX2, h2);
    chk({name, "_hex1"}, bus.HEX1, h1);
    chk({name, "_hex0"}, bus.HEX0, h0);
  endtask

  // Monitor: pops one expectation per presented event pulse / count update.
  always @(negedge clk) begin
    if (reset) begin
      prev_cnt <= bus.count;
    end else begin
      if ((bus.enter_evt | bus.exit_evt) != 2'b00) begin
        if (evt_sb.size() == 0) begin
          chk("unexpected_evt", {bus.enter_evt, bus.exit_evt}, 0);
        end else begin
          e = evt_sb.pop_front();
          chk("enter_evt", bus.enter_evt, e.ent);
          chk("exit_evt", bus.exit_evt, e.ext);
        end
      end
      if (bus.count != prev_cnt || bus.reject) begin
        if (upd_sb.size() == 0) begin
          chk("unexpected_update", {bus.count, bus.reject}, {prev_cnt, 1'b0});
        end else begin
          u = upd_sb.pop_front();
          chk("count_update", bus.count, u.cnt);
          chk("reject", bus.reject, u.rej);
        end
      end
      prev_cnt <= bus.count;
    end
  end

  task automatic expect_pass(input logic [1:0] ent, input logic [1:0] ext);
    int sum;
    int nc;
    logic rej;
    sum = m_cnt + $countones(ent) - $countones(ext);
    rej = (sum < 0) || (sum > Cap);
    nc  = (sum < 0) ? 0 : (sum > Cap) ? Cap : sum;
    if ((ent | ext) != 2'b00) evt_sb.push_back('{ent: ent, ext: ext});
    if (nc != m_cnt || rej) upd_sb.push_back('{cnt: 5'(nc), rej: rej});
    m_cnt = nc;
  endtask

  // Five steps of {a,b} per gate, four cycles each, then settle.
  task automatic run_seq(input logic [9:0] s0, input logic [9:0] s1,
                         input logic [1:0] ent, input logic [1:0] ext);
    expect_pass(ent, ext);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.a[0] = s0[9-2*k];
      bus.b[0] = s0[8-2*k];
      bus.a[1] = s1[9-2*k];
      bus.b[1] = s1[8-2*k];
      repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_reject", bus.reject, 0);
    chk("rst_evts", {bus.enter_evt, bus.exit_evt}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_hex("rst", 7'h46, 7'h47, 7'h06, 7'h08, 7'h2F, 7'h40);

    run_seq(SeqEnt, SeqIdle, 2'b01, 2'b00);
    chk("entry1_count", bus.count, 1);
    chk("entry1_empty", bus.empty, 0);
    chk_hex("one", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79);

    run_seq(SeqExt, SeqIdle, 2'b00, 2'b01);
    chk("exit1_count", bus.count, 0);
    chk_hex("clear", 7'h46, 7'h47, 7'h06, 7'h08, 7'h2F, 7'h40);

    run_seq(SeqBack, SeqIdle, 2'b00, 2'b00);
    run_seq(SeqErr, SeqIdle, 2'b00, 2'b00);
    chk("noevt_count", bus.count, 0);

    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 1) run_seq(SeqIdle, SeqEnt, 2'b10, 2'b00);
      else            run_seq(SeqEnt, SeqIdle, 2'b01, 2'b00);
    end
    chk("seven_count", bus.count, 7);
    run_seq(SeqEnt, SeqExt, 2'b01, 2'b10);
    chk("net0_count", bus.count, 7);

    for (int i = 0; i < 5; i++) run_seq(SeqEnt, SeqIdle, 2'b01, 2'b00);
    chk("twelve_count", bus.count, 12);
    chk_hex("twelve", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24);

    for (int i = 0; i < 12; i++) run_seq(SeqIdle, SeqEnt, 2'b10, 2'b00);
    chk("t24_count", bus.count, 24);
    chk("t24_full", bus.full, 0);
    run_seq(SeqEnt, SeqEnt, 2'b11, 2'b00);
    chk("sat_count", bus.count, Cap);
    chk("sat_full", bus.full, 1);
    chk_hex("full", 7'h0E, 7'h41, 7'h47, 7'h47, 7'h24, 7'h12);
    run_seq(SeqEnt, SeqIdle, 2'b01, 2'b00);
    chk("over_count", bus.count, Cap);

    for (int i = 0; i < 20; i++) run_seq(SeqExt, SeqIdle, 2'b00, 2'b01);
    chk("five_count", bus.count, 5);

    // Park gate0 in IN2, then reset asynchronously between edges.
    @(negedge clk);
    bus.a[0] = 1'b1;
    bus.b[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus.b[0] = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_empty", bus.empty, 1);
    m_cnt = 0;
    bus.a[0] = 1'b0;
    bus.b[0] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    bus.b[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_count", bus.count, 0);

    repeat (5) @(negedge clk);
    chk("evt_sb_drained", evt_sb.size(), 0);
    chk("upd_sb_drained", upd_sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
